// File: rtl/uart_text_receiver_if.sv
// Byte-in / character-read bus of the UART text receiver: received byte strobe
// from the UART core and the display read port.
interface uart_text_receiver_if #(
  parameter int AW = 8
) ();
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_char;

  modport master (output rx_data, output rx_valid, output rd_addr, input  rd_char);
  modport slave  (input  rx_data, input  rx_valid, input  rd_addr, output rd_char);
endinterface

// File: rtl/uart_text_receiver.sv
// Character terminal behind a UART receiver: decodes {lang, ascii} bytes, writes
// printable characters at a cursor into a ROWS x COLS buffer, executes control codes.
module uart_text_receiver #(
  parameter int COLS = 32,
  parameter int ROWS = 8,
  parameter int AW   = $clog2(COLS*ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_text_receiver_if.slave     bus,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [7:0]              last_char,
  output logic                    lang_mode,
  output logic                    busy,
  output logic                    rx_dropped
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS*ROWS-1);
  localparam logic [7:0]    BLANK     = 8'h20;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    last_q, last_d;
  logic          lang_q, lang_d;
  logic          drop_q, drop_d;

  logic          we;
  logic [AW-1:0] wa;
  logic [7:0]    wd;
  logic [6:0]    code;

  logic [7:0] mem [COLS*ROWS];

  assign code = bus.rx_data[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      last_q  <= BLANK;
      lang_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      lang_q  <= lang_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    lang_d  = lang_q;
    drop_d  = drop_q;
    we      = 1'b0;
    wa      = {row_q, col_q};
    wd      = BLANK;

    case (state_q)
      CLEAR: begin
        // Every byte arriving during a clear is lost, including the final cycle.
        we    = 1'b1;
        wa    = clr_q;
        clr_d = clr_q + 1'b1;
        col_d = '0;
        row_d = '0;
        if (bus.rx_valid) drop_d = 1'b1;
        if (clr_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        if (bus.rx_valid) begin
          if (code >= 7'h20 && code <= 7'h7E) begin
            we     = 1'b1;
            wd     = bus.rx_data;
            last_d = bus.rx_data;
            lang_d = bus.rx_data[7];
            col_d  = col_q + 1'b1;
            if (col_q == CW'(COLS-1)) row_d = row_q + 1'b1;
          end else if (code == 7'h0D) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else if (code == 7'h08) begin
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
            end else if (row_q != '0) begin
              row_d = row_q - 1'b1;
              col_d = CW'(COLS-1);
            end
            we = 1'b1;
            wa = {row_d, col_d};
          end else if (code == 7'h1B) begin
            state_d = CLEAR;
            clr_d   = '0;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read-first: a same-cycle write is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_char <= BLANK;
    else        bus.rd_char <= mem[bus.rd_addr];
  end

  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign last_char  = last_q;
  assign lang_mode  = lang_q;
  assign busy       = (state_q == CLEAR);
  assign rx_dropped = drop_q;
endmodule

// File: doc/uart_text_receiver.md
Name: uart_text_receiver

Overview:
- Receive-side counterpart of the keyboard/switch sender; sits behind the UART receiver's byte output.
- Decodes each received byte as {lang, 7-bit ASCII}, executes control codes and writes printable characters into a ROWS x COLS character buffer at a hardware cursor.
- Exposes a registered read port for the display path, plus cursor and status outputs for LEDs/7-seg.

Parameters:
- COLS, 32, characters per row; power of two.
- ROWS, 8, number of rows; power of two.
- AW, log2(COLS*ROWS) = 8, buffer address width; address = row*COLS + col.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte: bit7 = lang flag, [6:0] = ASCII code.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- rd_addr  in  AW  display read address.
- rd_char  out  8  registered buffer contents at rd_addr: {lang, ascii}.
- cursor_col  out  log2(COLS)  current column.
- cursor_row  out  log2(ROWS)  current row.
- last_char  out  8  last accepted printable byte.
- lang_mode  out  1  lang bit of last accepted printable byte.
- busy  out  1  high while the buffer is being cleared.
- rx_dropped  out  1  sticky; set when a byte arrives while busy.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - Registers go to cursor (0,0), last_char=8'h20, lang_mode=0, rx_dropped=0, rd_char=8'h20, busy=1.
  - State goes to CLEAR with clr_addr=0.
  - Buffer RAM contents are not reset; CLEAR initialises them.
- States:
  - CLEAR: write 8'h20 to mem[clr_addr] on each clock and increment clr_addr. After the write to address COLS*ROWS-1, go to IDLE, busy=0 and cursor=(0,0). Exactly COLS*ROWS cycles, so busy is 256 cycles with default parameters.
  - IDLE: act on rx_valid. Every action completes in one clock: mem write, cursor and status update all happen at the same edge.
- Decode in IDLE (c = rx_data[6:0]):
  - c in 0x20..0x7E: mem[cursor] <= rx_data; last_char <= rx_data; lang_mode <= rx_data[7]; cursor advances.
    - Advance: col+1. At col=COLS-1, go to col 0, row+1. At (ROWS-1, COLS-1), wrap to (0,0).
    - No scrolling.
  - c=0x0D (enter): col <= 0; row <= row+1 mod ROWS. No mem write.
  - c=0x08 (backspace): move the cursor back one cell and write 8'h20 there.
    - If col>0: col-1.
    - If col=0 and row>0: (row-1, COLS-1).
    - At (0,0): cursor stays and mem[0] <= 8'h20.
  - c=0x1B (escape): enter CLEAR with clr_addr=0, busy=1 from the next cycle.
  - Any other code: ignored, no state change.
  - The lang bit is ignored for control codes.
- Busy handling:
  - rx_valid while busy: the byte is discarded and rx_dropped <= 1.
  - rx_dropped is cleared only by reset.
  - rx_valid in the same cycle that CLEAR finishes is also dropped; busy is still 1 in that cycle.
- Read port:
  - rd_char <= mem[rd_addr] every clock; latency 1.
  - Read-first: if the same address is written in the same cycle, rd_char returns the old value, and the new value appears one cycle later.
  - Reads are valid during CLEAR and show partially cleared contents.
- Width rules:
  - Cursor counters wrap naturally because COLS and ROWS are powers of two.
  - Address = {row, col}.
- Reset mid-CLEAR or mid-write: reset wins. CLEAR restarts from address 0 after rst_n deasserts.
- Inference: block-RAM friendly, one write port and one read port.

Test Plan:
- Reset, then hold idle: busy=1 for exactly 256 cycles. Afterwards rd_char=8'h20 for every rd_addr 0..255, cursor=(0,0), rx_dropped=0.
- Send 8'h41 then 8'hC2: mem[0]=8'h41 and mem[1]=8'hC2; cursor=(0,2), last_char=8'hC2, lang_mode=1. Reading addr 1 shows 8'hC2 one cycle after rd_addr is applied.
- Cursor and newline sequence:
  - 255 printable 8'h61 bytes leave the cursor at (7,31); one more 8'h61 writes mem[255] and the cursor wraps to (0,0).
  - 8'h0D at (3,5) goes to (4,0); 8'h0D at (7,x) goes to (0,0).
- Backspace: at (2,0), 8'h08 moves to (1,31) and mem[63]=8'h20; at (0,0), 8'h08 keeps the cursor and mem[0]=8'h20. Bytes 8'h07 and 8'h7F leave buffer, cursor and last_char unchanged.
- Clear and drop: send 8'h1B, then 8'h41 ten cycles later. Required: busy=1 for 256 cycles, the 8'h41 is not written, rx_dropped=1, and the buffer ends all 8'h20 with cursor=(0,0).
- Reset mid-operation: assert rst_n=0 at cycle 100 of CLEAR and release it. CLEAR restarts and busy lasts a full 256 cycles; rx_dropped=0.
